// File: rtl/recirculacion_param.sv
// N-channel beat router between the FIFO/L1 layer and the probador.
// A registered mode steers beats to L1 or to the probador, and saturating counters track where beats went.
module recirculacion_param #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4,
    parameter int COUNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     IDL,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH-1:0]          valid_in,
    input  logic                     L1_pause,
    input  logic                     clr_cnt,
    output logic [N_CH*DATA_W-1:0]   L1_data,
    output logic [N_CH-1:0]          L1_valid,
    output logic [N_CH*DATA_W-1:0]   probador_data,
    output logic [N_CH-1:0]          probador_valid,
    output logic                     mode,
    output logic [COUNT_W-1:0]       cnt_l1,
    output logic [COUNT_W-1:0]       cnt_probe,
    output logic [COUNT_W-1:0]       cnt_drop
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int POP_W  = $clog2(N_CH + 1);
    localparam int SUM_W  = ((COUNT_W > POP_W) ? COUNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-COUNT_W){1'b0}}, {COUNT_W{1'b1}}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {PROBE = 1'b0, RECIRC = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    logic [N_CH*DATA_W-1:0] data_masked;
    logic                   route_l1, route_probe, route_drop;
    logic [POP_W-1:0]       pop_valid, pop_l1, pop_probe, pop_drop;

    function automatic logic [POP_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [POP_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc = acc + POP_W'(v[i]);
        end
        return acc;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] c,
                                                   input logic [POP_W-1:0]   p);
        logic [SUM_W-1:0] s;
        s = SUM_W'(c) + SUM_W'(p);
        if (s > CNT_MAX) begin
            s = CNT_MAX;
        end
        return s[COUNT_W-1:0];
    endfunction

    // Idle channels carry zero data on every output, whichever path is active.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
            assign data_masked[gi*DATA_W +: DATA_W] =
                valid_in[gi] ? data_in[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    // A mode change waits for a beat-free cycle, but never longer than MAX_HOLD cycles.
    always_comb begin
        state_next = state_reg;
        hold_next  = '0;
        if (IDL != state_reg) begin
            if (valid_in == '0 || hold_reg == HOLD_LAST) begin
                state_next = state_t'(IDL);
            end else begin
                hold_next = hold_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_reg <= PROBE;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    assign mode = state_reg;

    // Routing uses the mode before the edge, so a switching cycle's beats follow the old path.
    assign route_probe = (state_reg == PROBE);
    assign route_l1    = (state_reg == RECIRC) && !L1_pause;
    assign route_drop  = (state_reg == RECIRC) && L1_pause;

    assign pop_valid = popcount(valid_in);
    assign pop_l1    = route_l1    ? pop_valid : '0;
    assign pop_probe = route_probe ? pop_valid : '0;
    assign pop_drop  = route_drop  ? pop_valid : '0;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            L1_data        <= '0;
            L1_valid       <= '0;
            probador_data  <= '0;
            probador_valid <= '0;
        end else begin
            L1_data        <= route_l1    ? data_masked : '0;
            L1_valid       <= route_l1    ? valid_in    : '0;
            probador_data  <= route_probe ? data_masked : '0;
            probador_valid <= route_probe ? valid_in    : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L || clr_cnt) begin
            cnt_l1    <= '0;
            cnt_probe <= '0;
            cnt_drop  <= '0;
        end else begin
            cnt_l1    <= sat_add(cnt_l1, pop_l1);
            cnt_probe <= sat_add(cnt_probe, pop_probe);
            cnt_drop  <= sat_add(cnt_drop, pop_drop);
        end
    end

endmodule

// File: tb/tb_recirculacion_param.sv
// Vector-table bench for recirculacion_param (4 channels, 4-bit counters, MAX_HOLD=4).
module tb_recirculacion_param;

    localparam int N_CH = 4, DATA_W = 8, MAX_HOLD = 4, COUNT_W = 4;

    logic        clk = 1'b0;
    logic        reset_L, IDL, L1_pause, clr_cnt;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [31:0] L1_data, probador_data;
    logic [3:0]  L1_valid, probador_valid;
    logic        mode;
    logic [3:0]  cnt_l1, cnt_probe, cnt_drop;

    int n_checks = 0;
    int n_fail   = 0;

    recirculacion_param #(
        .N_CH(N_CH), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .reset_L(reset_L), .IDL(IDL), .data_in(data_in),
        .valid_in(valid_in), .L1_pause(L1_pause), .clr_cnt(clr_cnt),
        .L1_data(L1_data), .L1_valid(L1_valid),
        .probador_data(probador_data), .probador_valid(probador_valid),
        .mode(mode), .cnt_l1(cnt_l1), .cnt_probe(cnt_probe), .cnt_drop(cnt_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_l;
        logic        idl;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        pause;
        logic        clr;
        logic        e_mode;
        logic [3:0]  e_l1v;
        logic [31:0] e_l1d;
        logic [3:0]  e_pv;
        logic [31:0] e_pd;
        logic [3:0]  e_cl1;
        logic [3:0]  e_cpr;
        logic [3:0]  e_cdr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        reset_L  = v.rst_l;
        IDL      = v.idl;
        valid_in = v.valid;
        data_in  = v.data;
        L1_pause = v.pause;
        clr_cnt  = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL vec%0d scoreboard: got empty queue expected an entry", idx);
        end else begin
            e = exp_q.pop_front();
            check("mode",           idx, 32'(mode),           32'(e.e_mode));
            check("L1_valid",       idx, 32'(L1_valid),       32'(e.e_l1v));
            check("L1_data",        idx, L1_data,             e.e_l1d);
            check("probador_valid", idx, 32'(probador_valid), 32'(e.e_pv));
            check("probador_data",  idx, probador_data,       e.e_pd);
            check("cnt_l1",         idx, 32'(cnt_l1),         32'(e.e_cl1));
            check("cnt_probe",      idx, 32'(cnt_probe),      32'(e.e_cpr));
            check("cnt_drop",       idx, 32'(cnt_drop),       32'(e.e_cdr));
            $display("vec%0d rst_l=%0b idl=%0b valid=%b pause=%0b clr=%0b -> mode=%0b l1v=%b pv=%b cnt=%0d/%0d/%0d",
                     idx, e.rst_l, e.idl, e.valid, e.pause, e.clr, mode, L1_valid, probador_valid,
                     cnt_l1, cnt_probe, cnt_drop);
        end
    endtask

    initial begin
        reset_L = 1'b0; IDL = 1'b0; valid_in = '0; data_in = '0; L1_pause = 1'b0; clr_cnt = 1'b0;

        //            rst idl valid    data          pse clr  mode l1v     l1d           pv      pd            cl1 cpr cdr
        // reset with traffic present
        vecs.push_back('{0, 1, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 0});
        // probador path, all channels
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 0, 4, 0});
        // idle switch to L1; invalid data zeroed
        vecs.push_back('{1, 1, 4'b0000, 32'hDEADBEEF, 0, 0,   1, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 4, 0});
        // A5 on ch2 goes to L1, other channels masked
        vecs.push_back('{1, 1, 4'b0100, 32'h77A56655, 0, 0,   1, 4'b0100, 32'h00A50000, 4'b0000, 32'h0,        1, 4, 0});
        // clr: beats delivered but not counted
        vecs.push_back('{1, 1, 4'b1111, 32'h04030201, 0, 1,   1, 4'b1111, 32'h04030201, 4'b0000, 32'h0,        0, 0, 0});
        // L1 pause drops
        vecs.push_back('{1, 1, 4'b1011, 32'hFFFFFFFF, 1, 0,   1, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 3});
        vecs.push_back('{1, 1, 4'b1011, 32'hFFFFFFFF, 1, 0,   1, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 6});
        // back to probador on idle, then clear
        vecs.push_back('{1, 0, 4'b0000, 32'h0,        0, 0,   0, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 6});
        vecs.push_back('{1, 0, 4'b0000, 32'h0,        0, 1,   0, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 0});
        // forced switch after MAX_HOLD busy cycles
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C1, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C1, 0, 1, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C2, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C2, 0, 2, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C3, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C3, 0, 3, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C4, 0, 0,   1, 4'b0000, 32'h0,        4'b0001, 32'h000000C4, 0, 4, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C5, 0, 0,   1, 4'b0001, 32'h000000C5, 4'b0000, 32'h0,        1, 4, 0});
        // pending change cancelled by IDL returning; hold restarts
        vecs.push_back('{1, 0, 4'b0010, 32'h0000D100, 0, 0,   1, 4'b0010, 32'h0000D100, 4'b0000, 32'h0,        2, 4, 0});
        vecs.push_back('{1, 1, 4'b0010, 32'h0000D200, 0, 0,   1, 4'b0010, 32'h0000D200, 4'b0000, 32'h0,        3, 4, 0});
        vecs.push_back('{1, 0, 4'b0010, 32'h0000D300, 0, 0,   1, 4'b0010, 32'h0000D300, 4'b0000, 32'h0,        4, 4, 0});
        vecs.push_back('{1, 0, 4'b0010, 32'h0000D400, 0, 0,   1, 4'b0010, 32'h0000D400, 4'b0000, 32'h0,        5, 4, 0});
        vecs.push_back('{1, 0, 4'b0010, 32'h0000D500, 0, 0,   1, 4'b0010, 32'h0000D500, 4'b0000, 32'h0,        6, 4, 0});
        vecs.push_back('{1, 0, 4'b0010, 32'h0000D600, 0, 0,   0, 4'b0010, 32'h0000D600, 4'b0000, 32'h0,        7, 4, 0});
        // probador counter saturates at 15
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 7, 8, 0});
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 7, 12, 0});
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 7, 15, 0});
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 0,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 7, 15, 0});
        vecs.push_back('{1, 0, 4'b1111, 32'h44332211, 0, 1,   0, 4'b0000, 32'h0,        4'b1111, 32'h44332211, 0, 0, 0});
        // reset mid-burst in L1 mode with a pending change
        vecs.push_back('{1, 1, 4'b0000, 32'h0,        0, 0,   1, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 0});
        vecs.push_back('{1, 0, 4'b1111, 32'h88776655, 0, 0,   1, 4'b1111, 32'h88776655, 4'b0000, 32'h0,        4, 0, 0});
        vecs.push_back('{0, 0, 4'b1111, 32'h88776655, 0, 1,   0, 4'b0000, 32'h0,        4'b0000, 32'h0,        0, 0, 0});
        // hold counter restarted by reset: full MAX_HOLD wait again
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C1, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C1, 0, 1, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C2, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C2, 0, 2, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C3, 0, 0,   0, 4'b0000, 32'h0,        4'b0001, 32'h000000C3, 0, 3, 0});
        vecs.push_back('{1, 1, 4'b0001, 32'h000000C4, 0, 0,   1, 4'b0000, 32'h0,        4'b0001, 32'h000000C4, 0, 4, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
